// File: rtl/mem_arbiter.sv
// mem_arbiter: N-channel memory-port arbiter with optional lock-held grant.
// Build option: define MEM_ARB_RR_EN for round-robin selection; otherwise the
// lowest-index requester always wins and no pointer register exists.
// Memory-side signals are routed combinationally from the granted channel.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mem_arbiter #(
    parameter int unsigned N_CH = 2,
    parameter int unsigned DW   = `DATA_WIDTH,
    parameter int unsigned AW   = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [N_CH*AW-1:0]  i_ch_addr,
    input  logic [N_CH*DW-1:0]  i_ch_data,
    input  logic [N_CH-1:0]     i_ch_wr_valid,
    output logic [N_CH-1:0]     o_ch_wr_ready,
    input  logic [N_CH*3-1:0]   i_ch_wr_width,
    output logic [DW-1:0]       o_ch_data,
    output logic [N_CH-1:0]     o_ch_rd_valid,
    input  logic [N_CH-1:0]     i_ch_rd_ready,
    input  logic [N_CH-1:0]     i_ch_lock,
    output logic [AW-1:0]       o_addr,
    output logic [DW-1:0]       o_data,
    output logic                o_wr_valid,
    output logic [2:0]          o_wr_width,
    output logic                o_rd_ready,
    input  logic                i_wr_ready,
    input  logic [DW-1:0]       i_data,
    input  logic                i_rd_valid,
    output logic [N_CH-1:0]     o_grant,
    output logic                o_busy
);

    localparam int unsigned IW = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [N_CH-1:0] grant_q, grant_d;
    logic [N_CH-1:0] req;
    logic [IW-1:0]   win;
    logic            any_req;
    logic            done;

    assign req     = i_ch_wr_valid | i_ch_rd_ready;
    assign any_req = |req;

`ifdef MEM_ARB_RR_EN
    logic [IW-1:0] ptr_q, ptr_d;
    int            idx;

    // Winner: first requester strictly after the last-granted channel, cyclically.
    // Scanning from the farthest offset down lets the nearest requester win last.
    always_comb begin
        win = '0;
        idx = 0;
        for (int off = int'(N_CH); off >= 1; off--) begin
            idx = (int'(ptr_q) + off) % int'(N_CH);
            if (req[idx]) win = IW'(idx);
        end
    end
`else
    // Winner: lowest-index requester.
    always_comb begin
        win = '0;
        for (int k = int'(N_CH) - 1; k >= 0; k--) begin
            if (req[k]) win = IW'(k);
        end
    end
`endif

    // Route the granted channel to the memory side; everything is zero when idle.
    always_comb begin
        o_addr        = '0;
        o_data        = '0;
        o_wr_width    = '0;
        o_wr_valid    = 1'b0;
        o_rd_ready    = 1'b0;
        o_ch_wr_ready = '0;
        o_ch_rd_valid = '0;
        if (state_q == StGrant) begin
            o_addr     = i_ch_addr[int'(gidx_q)*AW +: AW];
            o_data     = i_ch_data[int'(gidx_q)*DW +: DW];
            o_wr_width = i_ch_wr_width[int'(gidx_q)*3 +: 3];
            o_wr_valid = i_ch_wr_valid[gidx_q];
            // A pending write masks the read request until it completes.
            o_rd_ready = i_ch_rd_ready[gidx_q] & ~i_ch_wr_valid[gidx_q];
            o_ch_wr_ready[gidx_q] = o_wr_valid & i_wr_ready;
            o_ch_rd_valid[gidx_q] = o_rd_ready & i_rd_valid;
        end
    end

    assign done      = (o_wr_valid & i_wr_ready) | (o_rd_ready & i_rd_valid);
    assign o_ch_data = i_data;
    assign o_grant   = grant_q;
    assign o_busy    = (state_q == StGrant);

    // Next-state: grant on any request, release on unlocked completion or abandon.
    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        grant_d = grant_q;
`ifdef MEM_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d      = StGrant;
                    gidx_d       = win;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
`ifdef MEM_ARB_RR_EN
                    ptr_d        = win;
`endif
                end
            end
            StGrant: begin
                if (done) begin
                    if (!i_ch_lock[gidx_q]) begin
                        state_d = StIdle;
                        grant_d = '0;
                    end
                end else if (!req[gidx_q] && !i_ch_lock[gidx_q]) begin
                    state_d = StIdle;
                    grant_d = '0;
                end
            end
        endcase
    end

    // State, grant and pointer registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            gidx_q  <= '0;
            grant_q <= '0;
`ifdef MEM_ARB_RR_EN
            ptr_q   <= IW'(N_CH - 1);
`endif
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
`ifdef MEM_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

endmodule
